// File: rtl/seg_digit_counter.sv
// Pushbutton-driven decimal counter: synchronizer, debouncer, hold/auto-repeat FSM
// and a registered active-low seven-segment decoder.
module seg_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic [3:0] digit,
  output logic [7:0] seg,
  output logic       seg_valid
);

  localparam int SYNC_STAGES = 2;
  localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  wire  [SYNC_STAGES-1:0] sync_next;
  logic                   sync_level;

  logic                   db_level_reg;
  logic [DB_W-1:0]        db_cnt_reg;
  logic                   pressed_reg;

  state_t                 state_reg, state_next;
  logic [TMR_W-1:0]       timer_reg, timer_next;
  logic                   inc;

  logic [3:0]             digit_reg, digit_next;
  logic [7:0]             seg_reg;
  logic                   seg_valid_reg;

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 8'hC0;
      4'd1:    seg_lut = 8'hF9;
      4'd2:    seg_lut = 8'hA4;
      4'd3:    seg_lut = 8'hB0;
      4'd4:    seg_lut = 8'h99;
      4'd5:    seg_lut = 8'h92;
      4'd6:    seg_lut = 8'h82;
      4'd7:    seg_lut = 8'hF8;
      4'd8:    seg_lut = 8'h80;
      4'd9:    seg_lut = 8'h90;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = button;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_level = sync_reg[SYNC_STAGES-1];

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= sync_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
      pressed_reg  <= 1'b0;
    end else begin
      pressed_reg <= ~db_level_reg;
      if (sync_level != db_level_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_level_reg <= ~db_level_reg;
          db_cnt_reg   <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Release is tested before expiry so a coincident release suppresses the increment.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    inc        = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (pressed_reg) begin
          inc        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!pressed_reg) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg == HOLD_LAST) begin
          inc        = 1'b1;
          state_next = REPEAT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      REPEAT: begin
        if (!pressed_reg) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg == REPEAT_LAST) begin
          inc        = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    digit_next = digit_reg;
    if (inc) begin
      digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
    end
  end

  // seg is decoded from digit_next so both outputs change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_reg     <= 4'd0;
      seg_reg       <= 8'hC0;
      seg_valid_reg <= 1'b0;
    end else begin
      digit_reg     <= digit_next;
      seg_reg       <= seg_lut(digit_next);
      seg_valid_reg <= inc;
    end
  end

  assign digit     = digit_reg;
  assign seg       = seg_reg;
  assign seg_valid = seg_valid_reg;

endmodule

// File: doc/seg_digit_counter.md
SEG_DIGIT_COUNTER -- requirements
Module: seg_digit_counter

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable sampled cycles needed to accept a button level change; legal values are 2 or more.
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 25000000, the cycles a debounced press must be held before auto-repeat starts; legal values are 2 or more.
REQ-003 The module SHALL have parameter REPEAT_CYCLES, default 10000000, the auto-repeat increment period in cycles; legal values are 2 or more.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port button, input, 1 bit: raw asynchronous pushbutton, active-low (0 = pressed).
REQ-007 The module SHALL have port digit, output, 4 bits: current count, 0 to 9.
REQ-008 The module SHALL have port seg, output, 8 bits: active-low seven-segment pattern; bit0 = a, bits 1 to 5 = b to f, bit6 = g, bit7 = dp.
REQ-009 The module SHALL have port seg_valid, output, 1 bit: a one-cycle pulse on each cycle in which digit and seg take a new value.

Function
REQ-010 button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce counter behaviour SHALL be as follows.
- The counter increments on each cycle in which the synchronized level differs from the debounced level.
- It clears on any cycle in which the two are equal.
- On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
REQ-012 Glitches shorter than DEBOUNCE_CYCLES sampled cycles SHALL NOT change the debounced level.
REQ-013 The FSM SHALL have the states IDLE, HOLD and REPEAT, and a timer that clears on every state transition.
REQ-014 In IDLE, a debounced press SHALL increment the count and move the FSM to HOLD.
REQ-015 In HOLD, a debounced release SHALL move the FSM to IDLE; otherwise, when the timer reaches HOLD_CYCLES-1, the count SHALL increment and the FSM SHALL move to REPEAT.
REQ-016 In REPEAT, a debounced release SHALL move the FSM to IDLE; otherwise, when the timer reaches REPEAT_CYCLES-1, the count SHALL increment and the timer SHALL clear.
REQ-017 If release and timer expiry occur in the same cycle, release SHALL win: no increment occurs and the FSM moves to IDLE.
REQ-018 An increment SHALL wrap 9 to 0; all other increments add 1.
REQ-019 digit, seg and seg_valid SHALL update on the same edge; seg is registered from the next digit value, never one cycle behind.
REQ-020 seg SHALL follow this table, hex, dp always off:
- 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
- 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
REQ-021 For a single press, digit SHALL change on the edge DEBOUNCE_CYCLES+3 cycles after the first edge that samples button = 0.
- 2 of those cycles are the synchronizer.
- DEBOUNCE_CYCLES of them are the debounce.
- 1 of them is the FSM.
REQ-022 A release SHALL never increment the count.
REQ-023 Exactly one increment SHALL occur per debounced press, plus one per auto-repeat period.
REQ-024 The timer SHALL be wide enough for max(HOLD_CYCLES, REPEAT_CYCLES) and SHALL never overflow.

Reset
REQ-025 On a rising edge with rst=1, the module SHALL set:
- digit = 0, seg = 8'hC0, seg_valid = 0;
- FSM = IDLE, timer = 0, debounce counter = 0;
- debounced level = released, synchronizer flops = 1.
REQ-026 rst SHALL take priority over every other event, including mid-press and auto-repeat; after reset, a still-held button requires a full debounce before it counts.
REQ-027 seg_valid SHALL NOT pulse on the reset edge or on the first cycle after reset.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-028 Reset, then button held at 1 for 100 cycles -> digit = 0, seg = C0 and seg_valid = 0 throughout.
REQ-029 Button held at 0 for 10 cycles, then at 1 -> digit becomes 1 and seg becomes F9 at cycle 7, with a single seg_valid pulse there; there is no change on release.
REQ-030 Button pulses at 0 for 3 cycles, repeated 5 times with 10-cycle gaps -> digit stays 0 and seg_valid is never asserted.
REQ-031 Ten clean presses -> digit runs 1 to 9 and then 0; the ninth press gives seg = 90 and the tenth gives seg = C0.
REQ-032 Button held at 0 continuously -> first increment at cycle 7, second at cycle 27, then one every 8 cycles; release timed to coincide with a repeat expiry produces no increment.
REQ-033 rst=1 for 1 cycle during REPEAT with digit = 5 -> next cycle digit = 0, seg = C0 and no seg_valid; with button still held, the next increment comes 7 cycles after reset deasserts.
